// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared forwarding encodings and hazard FSM state type.
// Imported by the hazard unit and by the EX operand muxes.
package hazard_forward_ctrl_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic {
      IDLE     = 1'b0,
      LU_STALL = 1'b1
   } hz_state_e;

   // The younger producer (EX/MEM) holds the newer value, so it wins.
   function automatic logic [1:0] fwd_pick(
      input logic exmem_hit,
      input logic memwb_hit
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (exmem_hit) begin
         sel = FWD_EXMEM;
      end else if (memwb_hit) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_match.sv
// Producer/consumer register match for one stage pair.
// Register 0 never matches when it is hardwired to zero.
module fwd_match #(
   parameter int REG_AW   = 4,
   parameter int ZERO_REG = 1
) (
   input  logic              regwrite,
   input  logic [REG_AW-1:0] rd,
   input  logic [REG_AW-1:0] src,
   output logic              hit
);

   logic rd_live;

   assign rd_live = (ZERO_REG == 0) || (rd != '0);
   assign hit     = regwrite && rd_live && (rd == src);

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX/MEM forwarding selects, load-use stall sequencer,
// memory-busy freeze and saturating stall-cycle counter.
module hazard_forward_ctrl
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int REG_AW   = 4,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16,
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_mem_regwrite,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] mem_rt,
   input  logic              ex_mem_memwrite,
   input  logic              mem_wb_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_memwrite,
   input  logic              flush,
   input  logic              dmem_busy,
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              fwd_mem_mem,
   output logic              pc_hold,
   output logic              if_id_hold,
   output logic              id_ex_bubble,
   output logic              freeze_all,
   output logic [CNT_W-1:0]  stall_cycles
);

   localparam int CW = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(LOAD_LAT - 1);

   logic a_exmem, a_memwb;
   logic b_exmem, b_memwb;
   logic mm_hit;
   logic lu_rs, lu_rt;
   logic hazard;

   hz_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_idle;
   logic          stall_now;

   fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_a_exmem (
      .regwrite (ex_mem_regwrite),
      .rd       (mem_rd),
      .src      (ex_rs),
      .hit      (a_exmem)
   );

   fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_a_memwb (
      .regwrite (mem_wb_regwrite),
      .rd       (wb_rd),
      .src      (ex_rs),
      .hit      (a_memwb)
   );

   fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_b_exmem (
      .regwrite (ex_mem_regwrite),
      .rd       (mem_rd),
      .src      (ex_rt),
      .hit      (b_exmem)
   );

   fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_b_memwb (
      .regwrite (mem_wb_regwrite),
      .rd       (wb_rd),
      .src      (ex_rt),
      .hit      (b_memwb)
   );

   fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_mem_mem (
      .regwrite (mem_wb_regwrite),
      .rd       (wb_rd),
      .src      (mem_rt),
      .hit      (mm_hit)
   );

   // A load in EX acts as the producer for the instruction in ID.
   fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_lu_rs (
      .regwrite (ex_memread),
      .rd       (ex_rd),
      .src      (id_rs),
      .hit      (lu_rs)
   );

   fwd_match #(.REG_AW(REG_AW), .ZERO_REG(ZERO_REG)) u_lu_rt (
      .regwrite (ex_memread),
      .rd       (ex_rd),
      .src      (id_rt),
      .hit      (lu_rt)
   );

   assign fwd_a_sel   = fwd_pick(a_exmem, a_memwb);
   assign fwd_b_sel   = fwd_pick(b_exmem, b_memwb);
   assign fwd_mem_mem = ex_mem_memwrite && mm_hit;

   // A store's rt is only needed in MEM, where MEM-to-MEM covers it.
   assign hazard = lu_rs || (lu_rt && !id_memwrite);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (hazard && !flush && !dmem_busy) begin
               state_d = LU_STALL;
               cnt_d   = CNT_LOAD;
            end
         end
         LU_STALL: begin
            if (!dmem_busy) begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
         end
      endcase
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   assign in_idle = (state_q == IDLE);

   assign stall_now = (in_idle && hazard && !flush)
                   || !in_idle
                   || dmem_busy;

   assign pc_hold    = stall_now;
   assign if_id_hold = stall_now;
   assign freeze_all = dmem_busy;

   assign id_ex_bubble = ((in_idle && hazard)
                       || (!in_idle && (cnt_q != '0)))
                       && !flush && !dmem_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if (stall_now && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed and randomized checks of hazard_forward_ctrl
// against a stall-remaining reference model.
module tb_hazard_forward_ctrl;

   localparam int AW  = 4;
   localparam int LL  = 2;
   localparam int CW  = 4;
   localparam int SAT = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          ex_mem_regwrite, ex_mem_memwrite, mem_wb_regwrite;
   logic [AW-1:0] mem_rd, mem_rt, wb_rd, ex_rs, ex_rt, ex_rd, id_rs, id_rt;
   logic          ex_memread, id_memwrite, flush, dmem_busy;
   logic [1:0]    fwd_a_sel, fwd_b_sel;
   logic          fwd_mem_mem, pc_hold, if_id_hold, id_ex_bubble, freeze_all;
   logic [CW-1:0] stall_cycles;

   int errs   = 0;
   int checks = 0;
   int left   = 0;
   int scount = 0;
   int nbub   = 0;

   hazard_forward_ctrl #(
      .REG_AW   (AW),
      .LOAD_LAT (LL),
      .CNT_W    (CW),
      .ZERO_REG (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .ex_mem_regwrite (ex_mem_regwrite),
      .mem_rd          (mem_rd),
      .mem_rt          (mem_rt),
      .ex_mem_memwrite (ex_mem_memwrite),
      .mem_wb_regwrite (mem_wb_regwrite),
      .wb_rd           (wb_rd),
      .ex_rs           (ex_rs),
      .ex_rt           (ex_rt),
      .ex_memread      (ex_memread),
      .ex_rd           (ex_rd),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_memwrite     (id_memwrite),
      .flush           (flush),
      .dmem_busy       (dmem_busy),
      .fwd_a_sel       (fwd_a_sel),
      .fwd_b_sel       (fwd_b_sel),
      .fwd_mem_mem     (fwd_mem_mem),
      .pc_hold         (pc_hold),
      .if_id_hold      (if_id_hold),
      .id_ex_bubble    (id_ex_bubble),
      .freeze_all      (freeze_all),
      .stall_cycles    (stall_cycles)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] m_sel(input logic [AW-1:0] s);
      if (ex_mem_regwrite && mem_rd != 0 && mem_rd == s) return 2'b10;
      if (mem_wb_regwrite && wb_rd != 0 && wb_rd == s) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit m_hz();
      return ex_memread && ex_rd != 0
         && (ex_rd == id_rs || (ex_rd == id_rt && !id_memwrite));
   endfunction

   // left = hold cycles still owed to an accepted load-use stall
   function automatic bit m_hold();
      return (left == 0 && m_hz() && !flush) || left > 0 || dmem_busy;
   endfunction

   function automatic bit m_bub();
      bit want;
      want = (left == 0) ? m_hz() : (left > 1);
      return want && !flush && !dmem_busy;
   endfunction

   task automatic cyc(input string tag);
      bit h, b, mm;
      #3;
      h  = m_hold();
      b  = m_bub();
      mm = ex_mem_memwrite && mem_wb_regwrite && wb_rd != 0 && wb_rd == mem_rt;
      chk({tag, ".fa"},  32'(fwd_a_sel),    32'(m_sel(ex_rs)));
      chk({tag, ".fb"},  32'(fwd_b_sel),    32'(m_sel(ex_rt)));
      chk({tag, ".mm"},  32'(fwd_mem_mem),  32'(mm));
      chk({tag, ".pc"},  32'(pc_hold),      32'(h));
      chk({tag, ".ifid"}, 32'(if_id_hold),  32'(h));
      chk({tag, ".bub"}, 32'(id_ex_bubble), 32'(b));
      chk({tag, ".frz"}, 32'(freeze_all),   32'(dmem_busy));
      chk({tag, ".cnt"}, 32'(stall_cycles), 32'(scount));
      if (id_ex_bubble === 1'b1) nbub++;
      @(posedge clk);
      if (rst) begin
         left   = 0;
         scount = 0;
      end else begin
         if (h) scount = (scount == SAT) ? SAT : scount + 1;
         if (flush) left = 0;
         else if (!dmem_busy) begin
            if (left == 0) begin
               if (m_hz()) left = LL;
            end else begin
               left = left - 1;
            end
         end
      end
      #1;
   endtask

   task automatic clr();
      rst = 0; ex_mem_regwrite = 0; ex_mem_memwrite = 0; mem_wb_regwrite = 0;
      mem_rd = 0; mem_rt = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0;
      id_rs = 0; id_rt = 0; ex_memread = 0; id_memwrite = 0;
      flush = 0; dmem_busy = 0;
   endtask

   initial begin
      clr();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      cyc("reset");
      rst = 0;
      cyc("idle");

      ex_mem_regwrite = 1; mem_rd = 3; mem_wb_regwrite = 1; wb_rd = 3;
      ex_rs = 3; ex_rt = 3;
      #3 chk("fwd_a_exmem", 32'(fwd_a_sel), 32'h2);
      cyc("fwd_exmem");
      ex_mem_regwrite = 0;
      #3 chk("fwd_a_memwb", 32'(fwd_a_sel), 32'h1);
      cyc("fwd_memwb");
      ex_mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
      #3 chk("fwd_a_zero", 32'(fwd_a_sel), 32'h0);
      cyc("fwd_zero");

      clr();
      ex_mem_memwrite = 1; mem_rt = 5; mem_wb_regwrite = 1; wb_rd = 5;
      #3 chk("mm_hit", 32'(fwd_mem_mem), 32'h1);
      cyc("mm_hit");
      wb_rd = 0;
      cyc("mm_zero");

      clr();
      nbub = 0;
      ex_memread = 1; ex_rd = 4; id_rs = 4;
      cyc("lu0");
      ex_memread = 0;
      repeat (3) cyc("lu");
      chk("lu_bubbles", 32'(nbub), 32'(LL));

      ex_memread = 1; ex_rd = 4; id_rs = 0; id_rt = 4; id_memwrite = 1;
      #3 chk("store_nostall", 32'(pc_hold), 32'h0);
      cyc("store");
      id_rs = 4;
      #3 chk("store_rs_stall", 32'(pc_hold), 32'h1);
      cyc("store_rs");
      clr();
      repeat (3) cyc("store_drain");

      nbub = 0;
      ex_memread = 1; ex_rd = 4; id_rs = 4;
      cyc("busy_lu");
      clr();
      dmem_busy = 1;
      repeat (3) cyc("busy");
      dmem_busy = 0;
      repeat (3) cyc("busy_resume");
      chk("busy_bubbles", 32'(nbub), 32'(LL));

      ex_memread = 1; ex_rd = 4; id_rs = 4; flush = 1;
      #3 chk("flush_hold", 32'(pc_hold), 32'h0);
      chk("flush_bub", 32'(id_ex_bubble), 32'h0);
      cyc("flush");
      clr();
      cyc("flush_after");

      ex_memread = 1; ex_rd = 4; id_rs = 4;
      cyc("rst_lu");
      clr();
      rst = 1;
      cyc("rst_mid");
      rst = 0;
      #3 chk("rst_cnt", 32'(stall_cycles), 32'h0);
      cyc("rst_after");

      dmem_busy = 1;
      repeat (20) cyc("sat");
      chk("sat_value", 32'(stall_cycles), 32'(SAT));
      clr();
      rst = 1;
      cyc("rst2");
      rst = 0;

      for (int i = 0; i < 600; i++) begin
         ex_mem_regwrite = 1'($urandom);
         ex_mem_memwrite = 1'($urandom);
         mem_wb_regwrite = 1'($urandom);
         mem_rd      = AW'($urandom_range(0, 4));
         mem_rt      = AW'($urandom_range(0, 4));
         wb_rd       = AW'($urandom_range(0, 4));
         ex_rs       = AW'($urandom_range(0, 4));
         ex_rt       = AW'($urandom_range(0, 4));
         ex_rd       = AW'($urandom_range(0, 4));
         id_rs       = AW'($urandom_range(0, 4));
         id_rt       = AW'($urandom_range(0, 4));
         ex_memread  = ($urandom_range(0, 2) == 0);
         id_memwrite = 1'($urandom);
         flush       = ($urandom_range(0, 7) == 0);
         dmem_busy   = ($urandom_range(0, 4) == 0);
         rst         = ($urandom_range(0, 59) == 0);
         cyc("rand");
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
